bcd_down_counter: RTL and testbench
===================================

# bcd_down_counter

Synchronous, loadable, cascadable BCD (decade) down-counter: the count-down counterpart of the library's 74x162-style decade up-counter benchmark. It holds `DIGITS` BCD digits and decrements by one per enabled cycle, wrapping 0…0 → 9…9. It provides a ripple-borrow output for chaining instances and registered zero and load-error flags. It sits in the sequential benchmark set alongside the combinational counter netlists and is the reference design for mapping flip-flop-bearing logic.

## Interface
- `DIGITS`, default 4: number of BCD digits (1..8); count width is 4·DIGITS.
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous clear, highest priority.
- `load` in 1: synchronous parallel load, second priority.
- `load_val` in 4·DIGITS: BCD value to load; digit k occupies bits [4k+3:4k], digit 0 least significant.
- `en` in 1: count enable.
- `bin` in 1: borrow-in / cascade enable; tie to 1 on the least significant instance.
- `count` out 4·DIGITS: current BCD value, registered.
- `bout` out 1: borrow-out, combinational; drives `bin` of the next instance.
- `zero` out 1: registered, high when `count` is all zero.
- `err` out 1: registered; high after a load containing any non-BCD digit.

## Operation
- Reset (`rst_n`=0, asynchronous): `count`=0, `zero`=1, `err`=0. `bout` then follows its equation.
- Per rising edge, priority order:
  - `clr`=1: `count`←0, `err`←0.
  - else `load`=1: each digit ← its `load_val` digit if ≤9, else 9. `err`←1 if any digit >9, else 0.
  - else `en`&`bin`=1: decrement by one in decimal.
  - else: hold all state.
- Decrement rule, per digit k:
  - Digit borrows when all lower digits are 0 (digit 0 always decrements).
  - A borrowing digit at 0 becomes 9; any other borrowing digit is reduced by 1.
  - Non-borrowing digits hold.
- All-zero wraps to all-nines (e.g. DIGITS=4: 0000 → 9999).
- `bout` = `en` & `bin` & (`count`==0) & ~`load` & ~`clr`. It is high exactly in the cycle that wraps this instance.
- `zero` is computed from the next-state value, so it is valid in the same cycle as `count`.
- `err` persists across counting. Only `clr`, reset, or a fully valid load clears it.
- `count` never holds a non-BCD digit.
- Reset asserted mid-count aborts immediately; nothing is retained.

## Timing
- Load, clear and decrement take effect on the edge where they are sampled. `count`, `zero` and `err` update one cycle after the input.
- `bout` has zero latency: it is combinational from `en`, `bin`, `load`, `clr` and the `count` register.
- Cascaded instances share `clk`. The upper instance decrements on the same edge the lower one wraps.
- Simultaneous cases:
  - `clr` with `load`: clear wins.
  - `load` with `en`&`bin`: load wins, no decrement, `bout`=0.
- `en`=0 or `bin`=0 freezes the count; `bout`=0.

## Structure
- Shared package `bcd_pkg`:
  - `bcd_digit_t` (4-bit logic).
  - constants `BCD_MAX`=4'd9 and `BCD_ZERO`=4'd0.
  - function `bcd_sat(bcd_digit_t)`, which returns 9 for any input >9.
- Sub-module `bcd_digit_dn`: one digit register with inputs `dec`, `ld`, `ld_val`, `clr`. Outputs `q`, plus `is_zero` for the borrow chain.
- Top-level work:
  - generate loop over DIGITS instances of `bcd_digit_dn`.
  - AND-chain of `is_zero` to form each digit's borrow.
  - `zero`/`err` registers and the `bout` equation.
- Target size: 150–250 lines.

## Test plan
- **Reset:** assert `rst_n`=0 mid-count at 0x0357. Expect `count`=0x0000, `zero`=1, `err`=0 immediately, before any clock edge.
- **Load and decrement:** DIGITS=4, load 0x1000, then en=bin=1 for 3 cycles. Expect 0x0999, 0x0998, 0x0997; `bout`=0 throughout.
- **Wrap:** load 0x0001, count 2 cycles. Expect 0x0000 with `zero`=1, then 0x9999. `bout`=1 only during the cycle `count`=0x0000 with en=bin=1.
- **Invalid load:** load 0x1A3F. Expect `count`=0x1939, `err`=1. Count one cycle: 0x1938, `err` still 1. Load 0x0042: `err`=0.
- **Priority:**
  - `clr`=1 with `load`=1 and load_val 0x5555: expect `count`=0.
  - `load`=1 with en=bin=1 and load_val 0x0000: expect `count`=0x0000, `bout`=0.
- **Cascade:** two DIGITS=2 instances, low `bout` → high `bin`. Load low=0x00, high=0x03 and count. Expect the combined value to go 0300 → 0299 → 0298. Low `bout` is asserted only in the first cycle.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD types, constants and helpers for the decade counter family.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_ZERO = 4'd0;

    // Clamp a raw nibble into the legal BCD range so no register ever holds A..F.
    function automatic bcd_digit_t bcd_sat(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

    function automatic logic bcd_invalid(input bcd_digit_t d);
        return d > BCD_MAX;
    endfunction

endpackage : bcd_pkg

// File: rtl/bcd_down_counter_if.sv
// Control and status bundle of one bcd_down_counter instance.
interface bcd_down_counter_if #(
    parameter int DIGITS = 4
);

    logic                  clr;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  en;
    logic                  bin;
    logic [4*DIGITS-1:0]   count;
    logic                  bout;
    logic                  zero;
    logic                  err;

    modport master (
        output clr, load, load_val, en, bin,
        input  count, bout, zero, err
    );

    modport slave (
        input  clr, load, load_val, en, bin,
        output count, bout, zero, err
    );

endinterface : bcd_down_counter_if

// File: rtl/bcd_digit_dn.sv
// One BCD digit register with clear > load > decrement priority.
module bcd_digit_dn
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       ld,
    input  bcd_digit_t ld_val,
    input  logic       dec,
    output bcd_digit_t q,
    output logic       is_zero
);

    // NOTE: state registers use non-blocking assignments so every digit samples
    // the pre-edge value of its neighbours' is_zero, exactly like real flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= BCD_ZERO;
        end else if (clr) begin
            q <= BCD_ZERO;
        end else if (ld) begin
            q <= bcd_sat(ld_val);
        end else if (dec) begin
            q <= (q == BCD_ZERO) ? BCD_MAX : q - 4'd1;
        end
    end

    assign is_zero = (q == BCD_ZERO);

endmodule : bcd_digit_dn

// File: rtl/bcd_down_counter.sv
// Loadable, cascadable BCD down-counter of DIGITS decades with ripple borrow-out
// and registered zero / load-error flags.
module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_down_counter_if.slave  bus
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0]      count;
    logic [DIGITS-1:0] is_zero;
    logic [DIGITS-1:0] borrow;
    logic [DIGITS-1:0] bad;
    logic              step;
    logic              all_zero;
    logic              upper_zero;
    logic              any_bad;
    logic              zero_q;
    logic              zero_nxt;
    logic              err_q;
    logic              err_nxt;

    // A decrement happens only when neither clear nor load claims the edge.
    assign step = bus.en & bus.bin & ~bus.load & ~bus.clr;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        if (k == 0) begin : g_lsd
            assign borrow[k] = 1'b1;
        end else begin : g_upper
            assign borrow[k] = borrow[k-1] & is_zero[k-1];
        end

        assign bad[k] = bcd_invalid(bus.load_val[4*k +: 4]);

        bcd_digit_dn u_digit (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (bus.clr),
            .ld      (bus.load),
            .ld_val  (bus.load_val[4*k +: 4]),
            .dec     (step & borrow[k]),
            .q       (count[4*k +: 4]),
            .is_zero (is_zero[k])
        );
    end

    assign all_zero = &is_zero;
    assign any_bad  = |bad;

    // NOTE: every variable assigned in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        upper_zero = 1'b1;
        for (int k = 1; k < DIGITS; k++) begin
            upper_zero = upper_zero & is_zero[k];
        end
    end

    // Flags track the next count so they line up with count in the same cycle.
    always_comb begin
        zero_nxt = zero_q;
        err_nxt  = err_q;
        if (bus.clr) begin
            zero_nxt = 1'b1;
            err_nxt  = 1'b0;
        end else if (bus.load) begin
            // Saturation never turns a non-zero digit into zero.
            zero_nxt = (bus.load_val == '0);
            err_nxt  = any_bad;
        end else if (step) begin
            zero_nxt = upper_zero & (count[3:0] == 4'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b1;
            err_q  <= 1'b0;
        end else begin
            zero_q <= zero_nxt;
            err_q  <= err_nxt;
        end
    end

    assign bus.count = count;
    assign bus.zero  = zero_q;
    assign bus.err   = err_q;
    assign bus.bout  = step & all_zero;

endmodule : bcd_down_counter

// File: tb/tb_bcd_down_counter.sv
// Scoreboard bench: a 4-digit instance plus a cascaded pair of 2-digit instances.
module tb_bcd_down_counter;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    bcd_down_counter_if #(.DIGITS(4)) bus4 ();
    bcd_down_counter_if #(.DIGITS(2)) lo_bus ();
    bcd_down_counter_if #(.DIGITS(2)) hi_bus ();

    bcd_down_counter #(.DIGITS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus4));
    bcd_down_counter #(.DIGITS(2)) u_lo (.clk(clk), .rst_n(rst_n), .bus(lo_bus));
    bcd_down_counter #(.DIGITS(2)) u_hi (.clk(clk), .rst_n(rst_n), .bus(hi_bus));

    assign hi_bus.bin = lo_bus.bout;

    typedef struct {
        logic [15:0] count;
        logic        zero;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] csb[$];

    int checks   = 0;
    int failures = 0;

    int m_val;
    bit m_err;
    int c_val;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          t;
        r = '0;
        t = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // One cycle on the 4-digit counter: drive, check bout, model, push, clock, pop, compare.
    task automatic step4(input string tag, input bit clr, input bit load,
                         input logic [15:0] val, input bit en, input bit bin);
        exp_t e;
        exp_t g;
        int   dec;
        bit   bad;
        bus4.clr      = clr;
        bus4.load     = load;
        bus4.load_val = val;
        bus4.en       = en;
        bus4.bin      = bin;
        #1;
        check({tag, ".bout"}, 32'(bus4.bout),
              32'(en && bin && (m_val == 0) && !load && !clr));
        if (clr) begin
            m_val = 0;
            m_err = 1'b0;
        end else if (load) begin
            dec = 0;
            bad = 1'b0;
            for (int k = 3; k >= 0; k--) begin
                if (val[4*k +: 4] > 4'd9) begin
                    bad = 1'b1;
                    dec = dec * 10 + 9;
                end else begin
                    dec = dec * 10 + int'(val[4*k +: 4]);
                end
            end
            m_val = dec;
            m_err = bad;
        end else if (en && bin) begin
            m_val = (m_val == 0) ? 9999 : m_val - 1;
        end
        e.count = to_bcd(m_val);
        e.zero  = (m_val == 0);
        e.err   = m_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            g = sb.pop_front();
            check({tag, ".count"}, 32'(bus4.count), 32'(g.count));
            check({tag, ".zero"},  32'(bus4.zero),  32'(g.zero));
            check({tag, ".err"},   32'(bus4.err),   32'(g.err));
        end
    endtask

    // One cycle on the cascaded pair; hi/lo given as decimal 0..99.
    task automatic step_casc(input string tag, input bit load, input int hi, input int lo,
                             input bit en);
        logic [15:0] th;
        logic [15:0] tl;
        logic [15:0] g;
        th = to_bcd(hi);
        tl = to_bcd(lo);
        lo_bus.load     = load;
        hi_bus.load     = load;
        lo_bus.load_val = tl[7:0];
        hi_bus.load_val = th[7:0];
        lo_bus.en       = en;
        hi_bus.en       = en;
        #1;
        check({tag, ".lo_bout"}, 32'(lo_bus.bout), 32'(en && !load && (c_val % 100 == 0)));
        if (load) begin
            c_val = hi * 100 + lo;
        end else if (en) begin
            c_val = (c_val == 0) ? 9999 : c_val - 1;
        end
        csb.push_back(to_bcd(c_val));
        @(posedge clk);
        #1;
        if (csb.size() == 0) begin
            check({tag, ".csb_empty"}, 32'd1, 32'd0);
        end else begin
            g = csb.pop_front();
            check({tag, ".count"}, 32'({hi_bus.count, lo_bus.count}), 32'(g));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus4.clr = 1'b0; bus4.load = 1'b0; bus4.load_val = '0; bus4.en = 1'b0; bus4.bin = 1'b1;
        lo_bus.clr = 1'b0; lo_bus.load = 1'b0; lo_bus.load_val = '0; lo_bus.en = 1'b0;
        lo_bus.bin = 1'b1;
        hi_bus.clr = 1'b0; hi_bus.load = 1'b0; hi_bus.load_val = '0; hi_bus.en = 1'b0;
        m_val = 0;
        m_err = 1'b0;
        c_val = 0;
        #12;
        check("rst.count", 32'(bus4.count), 32'h0);
        check("rst.zero",  32'(bus4.zero),  32'd1);
        check("rst.err",   32'(bus4.err),   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Load and decrement across a digit boundary.
        step4("ld1000", 0, 1, 16'h1000, 0, 1);
        for (int i = 0; i < 3; i++) step4("dec", 0, 0, 16'h0000, 1, 1);

        // Wrap through zero.
        step4("ld0001", 0, 1, 16'h0001, 0, 1);
        step4("to_zero", 0, 0, 16'h0000, 1, 1);
        step4("wrap", 0, 0, 16'h0000, 1, 1);
        step4("after_wrap", 0, 0, 16'h0000, 1, 1);

        // Hold when bin is low, even at zero.
        step4("ld0000", 0, 1, 16'h0000, 0, 1);
        step4("hold_bin0", 0, 0, 16'h0000, 1, 0);

        // Invalid load saturates and err persists across counting.
        step4("ld1A3F", 0, 1, 16'h1A3F, 0, 1);
        step4("dec_err", 0, 0, 16'h0000, 1, 1);
        step4("ld0042", 0, 1, 16'h0042, 0, 1);

        // Priority cases.
        step4("ldBAD", 0, 1, 16'hF000, 0, 1);
        step4("clr_ld", 1, 1, 16'h5555, 1, 1);
        step4("ld_en", 0, 1, 16'h0000, 1, 1);

        // Asynchronous reset mid-count.
        step4("ld0358", 0, 1, 16'h0358, 0, 1);
        step4("to0357", 0, 0, 16'h0000, 1, 1);
        check("pre_rst.count", 32'(bus4.count), 32'h0357);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.count", 32'(bus4.count), 32'h0);
        check("async_rst.zero",  32'(bus4.zero),  32'd1);
        check("async_rst.err",   32'(bus4.err),   32'd0);
        m_val = 0;
        m_err = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus4.en = 1'b0;

        // Cascade: 0300 -> 0299 -> 0298.
        step_casc("c_ld", 1, 3, 0, 0);
        step_casc("c_dec1", 0, 0, 0, 1);
        step_casc("c_dec2", 0, 0, 0, 1);
        step_casc("c_dec3", 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bcd_down_counter
